div_iter_param: RTL and testbench

Parametrised iterative restoring divider for the pipelined CPU's EX/MEM multi-cycle path. It is the next-generation replacement of the fixed 32-bit, 1-bit-per-cycle divider. Added capabilities:
- configurable operand width and bits-per-cycle;
- valid/ready handshakes on both input and output;
- divide-by-zero detection with a fast path;
- synchronous flush for exception/branch cancellation.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 17 +
 rtl/div_iter_param.sv | 94 +++++++++
 tb/tb_div_iter_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding and sizing helpers for the iterative divider
package div_pkg;
   typedef logic [1:0] div_state_t;
   localparam div_state_t IDLE = 2'd0;
   localparam div_state_t CALC = 2'd1;
   localparam div_state_t DONE = 2'd2;
   function automatic int iter_of(input int width, input int steps);
      return width / steps;
   endfunction
   function automatic int cnt_w_of(input int width, input int steps);
      return $clog2(width / steps + 1);
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring step on a WIDTH+1 bit partial remainder
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             bit_in,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);
   logic [WIDTH+1:0] diff;
   always_comb begin
      diff = {rem_in, bit_in} - {2'b0, divisor};
      q_bit = ~diff[WIDTH+1];
      rem_out = q_bit ? diff[WIDTH:0] : {rem_in[WIDTH-1:0], bit_in};
   end
endmodule

// File: rtl/div_iter_param.sv
// div_iter_param: iterative restoring divider, STEPS quotient bits per cycle, valid/ready both sides
module div_iter_param
   import div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEPS = 1
) (
   input  logic             div_clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);
   localparam int ITER = iter_of(WIDTH, STEPS);
   localparam int CW = cnt_w_of(WIDTH, STEPS);
   div_state_t state;
   logic sign_x, sign_y, accept, last;
   logic [WIDTH-1:0] ax, ay, ax_next;
   logic [WIDTH:0] rem;
   logic [WIDTH:0] rem_c [STEPS+1];
   logic [STEPS-1:0] q_vec;
   logic [CW-1:0] cnt;
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   assign busy = state != IDLE;
   assign accept = in_valid & in_ready & ~flush;
   assign last = cnt == CW'(ITER - 1);
   assign rem_c[0] = rem;
   // ax holds the not-yet-consumed dividend bits on top and collects quotient bits at the bottom
   assign ax_next = (ax << STEPS) | WIDTH'(q_vec);
   for (genvar g = 0; g < STEPS; g++) begin : g_step
      div_step #(.WIDTH(WIDTH)) u_step (
         .rem_in (rem_c[g]),
         .divisor(ay),
         .bit_in (ax[WIDTH-1-g]),
         .rem_out(rem_c[g+1]),
         .q_bit  (q_vec[STEPS-1-g])
      );
   end
   always_ff @(posedge div_clk) begin
      if (rst) begin
         state <= IDLE;
         quotient <= '0;
         remainder <= '0;
         div_by_zero <= 1'b0;
         sign_x <= 1'b0;
         sign_y <= 1'b0;
         ax <= '0;
         ay <= '0;
         rem <= '0;
         cnt <= '0;
      end else if (flush && state != IDLE) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sign_x <= div_signed & x[WIDTH-1];
               sign_y <= div_signed & y[WIDTH-1];
               ax <= (div_signed & x[WIDTH-1]) ? -x : x;
               ay <= (div_signed & y[WIDTH-1]) ? -y : y;
               rem <= '0;
               cnt <= '0;
               div_by_zero <= y == '0;
               if (y == '0) begin
                  quotient <= '1;
                  remainder <= x;
               end
               state <= (y == '0) ? DONE : CALC;
            end
            CALC: begin
               ax <= ax_next;
               rem <= rem_c[STEPS];
               cnt <= cnt + 1'b1;
               if (last) begin
                  state <= DONE;
                  quotient <= (sign_x ^ sign_y) ? -ax_next : ax_next;
                  remainder <= sign_x ? -rem_c[STEPS][WIDTH-1:0] : rem_c[STEPS][WIDTH-1:0];
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_iter_param.sv
// tb_div_iter_param: directed table, handshake/flush/reset sequences and model-checked random vectors
module tb_div_iter_param;
   logic div_clk, rst, div_signed, flush, out_ready;
   logic [31:0] x, y;
   logic [2:0] iv;
   logic ir0, ov0, bz0, bs0, ir1, ov1, bz1, bs1, ir2, ov2, bz2, bs2;
   logic [31:0] q0, r0, q1, r1;
   logic [15:0] q2, r2;
   int total = 0;
   int bad = 0;
   typedef struct {
      int d;
      logic sg;
      logic [31:0] a, b, q, r;
      logic z;
      int lat;
   } vec_t;
   vec_t tv[14];
   div_iter_param #(.WIDTH(32), .STEPS(1)) dut0 (
      .div_clk(div_clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .div_signed(div_signed),
      .x(x), .y(y), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
      .quotient(q0), .remainder(r0), .div_by_zero(bz0), .busy(bs0));
   div_iter_param #(.WIDTH(32), .STEPS(4)) dut1 (
      .div_clk(div_clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .div_signed(div_signed),
      .x(x), .y(y), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
      .quotient(q1), .remainder(r1), .div_by_zero(bz1), .busy(bs1));
   div_iter_param #(.WIDTH(16), .STEPS(2)) dut2 (
      .div_clk(div_clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .div_signed(div_signed),
      .x(x[15:0]), .y(y[15:0]), .flush(flush), .out_valid(ov2), .out_ready(out_ready),
      .quotient(q2), .remainder(r2), .div_by_zero(bz2), .busy(bs2));
   initial div_clk = 1'b0;
   always #5 div_clk = ~div_clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   function automatic logic get_ir(input int d);
      return d == 0 ? ir0 : d == 1 ? ir1 : ir2;
   endfunction
   function automatic logic get_ov(input int d);
      return d == 0 ? ov0 : d == 1 ? ov1 : ov2;
   endfunction
   function automatic logic get_bz(input int d);
      return d == 0 ? bz0 : d == 1 ? bz1 : bz2;
   endfunction
   function automatic logic [31:0] get_q(input int d);
      return d == 0 ? q0 : d == 1 ? q1 : {16'b0, q2};
   endfunction
   function automatic logic [31:0] get_r(input int d);
      return d == 0 ? r0 : d == 1 ? r1 : {16'b0, r2};
   endfunction
   // Reference: 64-bit host arithmetic, truncating division, remainder takes the dividend's sign
   function automatic void ref_div(input int w, input logic sg, input logic [31:0] a, b,
                                   output logic [31:0] q, output logic [31:0] r);
      logic [63:0] m, ua, ub;
      longint sa, sb;
      m = (64'd1 << w) - 64'd1;
      ua = {32'b0, a} & m;
      ub = {32'b0, b} & m;
      sa = longint'(ua);
      sb = longint'(ub);
      if (sg && ua[w-1]) sa = sa - (longint'(1) << w);
      if (sg && ub[w-1]) sb = sb - (longint'(1) << w);
      if (ub == 64'd0) begin
         q = 32'(m);
         r = 32'(ua);
      end else begin
         q = 32'(64'(sa / sb) & m);
         r = 32'(64'(sa % sb) & m);
      end
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge div_clk);
      #1;
   endtask
   task automatic start(input int d, input logic sg, input logic [31:0] a, input logic [31:0] b);
      chk("accept_ready", 32'(get_ir(d)), 32'd1);
      x = a;
      y = b;
      div_signed = sg;
      iv[d] = 1'b1;
      tick();
      iv[d] = 1'b0;
      x = $urandom;
      y = $urandom;
      div_signed = ~sg;
   endtask
   task automatic wait_ov(input int d, output int lat);
      lat = 1;
      while (!get_ov(d) && lat < 100) begin
         tick();
         lat++;
      end
   endtask
   task automatic take();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask
   task automatic do_op(input string nm, input int d, input logic sg, input logic [31:0] a, b,
                        input logic [31:0] eq, er, input logic ez, input int el);
      int lat;
      start(d, sg, a, b);
      wait_ov(d, lat);
      chk({nm, "_lat"}, 32'(lat), 32'(el));
      chk({nm, "_q"}, get_q(d), eq);
      chk({nm, "_r"}, get_r(d), er);
      chk({nm, "_dbz"}, 32'(get_bz(d)), 32'(ez));
      take();
   endtask
   initial begin
      logic [31:0] mq, mr, a, b, cq, cr;
      logic sg, seen;
      int lat, n;
      rst = 1'b1;
      iv = '0;
      div_signed = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      x = '0;
      y = '0;
      tv[0]  = '{0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33};
      tv[1]  = '{0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
      tv[2]  = '{0, 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 33};
      tv[3]  = '{0, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1};
      tv[4]  = '{0, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1};
      tv[5]  = '{0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33};
      tv[6]  = '{1, 1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'd0, 1'b0, 9};
      tv[7]  = '{2, 1'b0, 32'h0000FFFF, 32'd3, 32'h00005555, 32'd0, 1'b0, 9};
      tv[8]  = '{0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 33};
      tv[9]  = '{0, 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33};
      tv[10] = '{1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 9};
      tv[11] = '{2, 1'b1, 32'h0000FFF9, 32'd2, 32'h0000FFFD, 32'h0000FFFF, 1'b0, 9};
      tv[12] = '{2, 1'b1, 32'h00008000, 32'h0000FFFF, 32'h00008000, 32'd0, 1'b0, 9};
      tv[13] = '{0, 1'b1, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1};
      repeat (2) tick();
      chk("rst_in_ready", 32'(ir0), 32'd1);
      chk("rst_out_valid", 32'(ov0), 32'd0);
      chk("rst_busy", 32'(bs0), 32'd0);
      chk("rst_q", q0, 32'd0);
      chk("rst_r", r0, 32'd0);
      chk("rst_dbz", 32'(bz0), 32'd0);
      chk("rst_q16", {16'b0, q2}, 32'd0);
      rst = 1'b0;
      tick();
      for (int i = 0; i < 14; i++)
         do_op($sformatf("vec%0d", i), tv[i].d, tv[i].sg, tv[i].a, tv[i].b,
               tv[i].q, tv[i].r, tv[i].z, tv[i].lat);
      // Backpressure: result must hold while the consumer stalls
      start(0, 1'b0, 32'd100, 32'd7);
      wait_ov(0, lat);
      chk("bp_lat", 32'(lat), 32'd33);
      for (int i = 0; i < 5; i++) begin
         chk("bp_q", q0, 32'd14);
         chk("bp_r", r0, 32'd2);
         chk("bp_valid", 32'(ov0), 32'd1);
         chk("bp_in_ready", 32'(ir0), 32'd0);
         tick();
      end
      take();
      chk("bp_release_ready", 32'(ir0), 32'd1);
      chk("bp_release_valid", 32'(ov0), 32'd0);
      do_op("b2b", 0, 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 33);
      // Flush in CALC with a competing in_valid and out_ready
      start(0, 1'b0, 32'd100, 32'd7);
      repeat (9) tick();
      chk("fl_busy_before", 32'(bs0), 32'd1);
      flush = 1'b1;
      iv[0] = 1'b1;
      out_ready = 1'b1;
      x = 32'd50;
      y = 32'd5;
      tick();
      flush = 1'b0;
      iv[0] = 1'b0;
      out_ready = 1'b0;
      chk("fl_in_ready", 32'(ir0), 32'd1);
      chk("fl_busy", 32'(bs0), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         seen |= ov0 | bs0;
         tick();
      end
      chk("fl_no_result", 32'(seen), 32'd0);
      do_op("after_fl", 0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
      // Flush while a result waits in DONE
      start(0, 1'b0, 32'd9, 32'd0);
      chk("fl_done_valid", 32'(ov0), 32'd1);
      flush = 1'b1;
      out_ready = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b0;
      chk("fl_done_dropped", 32'(ov0), 32'd0);
      chk("fl_done_ready", 32'(ir0), 32'd1);
      // Reset in CALC clears outputs, including the previous result
      do_op("pre_rst", 0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
      start(0, 1'b0, 32'd100, 32'd7);
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_q", q0, 32'd0);
      chk("mr_r", r0, 32'd0);
      chk("mr_valid", 32'(ov0), 32'd0);
      chk("mr_busy", 32'(bs0), 32'd0);
      chk("mr_in_ready", 32'(ir0), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         seen |= ov0;
         tick();
      end
      chk("mr_no_result", 32'(seen), 32'd0);
      for (int d = 0; d < 3; d++) begin
         n = d == 0 ? 150 : 500;
         for (int k = 0; k < n; k++) begin
            sg = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 5))
               0: b = 32'd0;
               1, 2: b = 32'($urandom_range(1, 20));
               3: b = -32'($urandom_range(1, 20));
               default: b = $urandom;
            endcase
            if (d == 2 && b[15:0] == 16'd0) b = 32'd0;
            ref_div(d == 2 ? 16 : 32, sg, a, b, mq, mr);
            cq = mq;
            cr = mr;
            do_op($sformatf("rnd%0d_%0d", d, k), d, sg, a, b, cq, cr,
                  (d == 2 ? b[15:0] == 16'd0 : b == 32'd0),
                  (d == 2 ? b[15:0] == 16'd0 : b == 32'd0) ? 1 : (d == 0 ? 33 : 9));
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
